// File: rtl/fifo_fill_pkg.sv
// ============================================================================
// Module      : fifo_fill_pkg
// Description : Shared state encoding and default widths for the FIFO fill
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_fill_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        PUSH = 3'd3,
        DONE = 3'd4
    } fill_state_t;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int WORD_BYTES_DEF = 8;
    localparam int WORD_W         = DATA_WIDTH_DEF * WORD_BYTES_DEF;

endpackage

`default_nettype wire

// File: rtl/word_unpacker.sv
// ============================================================================
// Module      : word_unpacker
// Description : Holds one fetched memory word and presents it byte by byte,
//               LSB first, with a flag on the final byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_unpacker #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [DATA_WIDTH*WORD_BYTES-1:0] load_word,
    input  logic                             advance,
    output logic [DATA_WIDTH-1:0]            byte_out,
    output logic                             last_byte
);

    localparam int               CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WORD_BYTES - 1);

    logic [DATA_WIDTH*WORD_BYTES-1:0] r_word;
    logic [CNT_W-1:0]                 r_byte_cnt;
    logic [DATA_WIDTH-1:0]            w_bytes [WORD_BYTES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= '0;
            r_byte_cnt <= '0;
        end else if (load) begin
            r_word     <= load_word;
            r_byte_cnt <= '0;
        end else if (advance) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_bytes
            assign w_bytes[gi] = r_word[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign byte_out  = w_bytes[r_byte_cnt];
    assign last_byte = (r_byte_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/fifo_fill_sched.sv
// ============================================================================
// Module      : fifo_fill_sched
// Description : Fetches one word per FIFO over an Avalon-MM read port and
//               pushes its bytes into the matching FIFO. Optional fill-cycle
//               counter enabled by FIFO_FILL_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_fill_sched
    import fifo_fill_pkg::*;
#(
    parameter int NUM_FIFOS  = 9,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int WORD_BYTES = WORD_BYTES_DEF,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic                             mem_read,
    input  logic                             mem_waitrequest,
    input  logic [DATA_WIDTH*WORD_BYTES-1:0] mem_readdata,
    input  logic                             mem_readdatavalid,
    output logic [NUM_FIFOS-1:0]             fifo_wren,
    output logic [DATA_WIDTH-1:0]            fifo_wdata,
    input  logic [NUM_FIFOS-1:0]             fifo_full,
    output logic                             busy,
    output logic                             fill_done
`ifdef FIFO_FILL_PERF_EN
    ,
    output logic [15:0]                      fill_cycles
`endif
);

    localparam int               IDX_W      = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_FIFOS - 1);

    fill_state_t           r_state;
    fill_state_t           w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_load;
    logic                  w_write;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_byte;

    // Only the response to our own outstanding read is captured.
    assign w_load = (r_state == WAIT) && mem_readdatavalid;

    word_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_BYTES (WORD_BYTES)
    ) u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .load_word (mem_readdata),
        .advance   (w_write),
        .byte_out  (w_byte),
        .last_byte (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_write     = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        fifo_wren   = '0;
        fifo_wdata  = '0;
        busy        = 1'b0;
        fill_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = REQ;
                    w_idx_nxt   = '0;
                end
            end
            REQ: begin
                busy        = 1'b1;
                mem_read    = 1'b1;
                mem_address = ADDR_WIDTH'(r_idx);
                if (!mem_waitrequest) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (mem_readdatavalid) begin
                    w_state_nxt = PUSH;
                end
            end
            PUSH: begin
                busy             = 1'b1;
                fifo_wdata       = w_byte;
                // A full FIFO stalls the current byte in place.
                w_write          = !fifo_full[r_idx];
                fifo_wren[r_idx] = w_write;
                if (w_write && w_last) begin
                    if (r_idx == c_last_idx) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = REQ;
                    end
                end
            end
            DONE: begin
                fill_done   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef FIFO_FILL_PERF_EN
    logic [15:0] r_fill_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_cycles <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_fill_cycles <= '0;
        end else if (busy && (r_fill_cycles != 16'hFFFF)) begin
            r_fill_cycles <= r_fill_cycles + 16'd1;
        end
    end

    assign fill_cycles = r_fill_cycles;
`endif

endmodule

`default_nettype wire
